// File: rtl/instmem_pkg.sv
// Shared types and constants for the programmable instruction memory.
package instmem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    READY = 2'd1,
    LOAD  = 2'd2
  } state_e;

  localparam logic [31:0] NOP_WORD      = 32'h0000_0013;
  localparam int          DEFAULT_DEPTH = 64;

  // Even parity: stored bit makes the XOR of all stored bits zero.
  function automatic logic even_par(input logic [31:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/instmem_ram_1r1w.sv
// Instruction storage array: one synchronous write port shared by the clear
// sweep and the program loader, plus one registered read port for fetches.
module instmem_ram_1r1w #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int W     = 32
) (
  input  logic          clk,
  input  logic          clr_we,
  input  logic [AW-1:0] clr_addr,
  input  logic [W-1:0]  clr_wdata,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [W-1:0]  ld_wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0]  mem [DEPTH];
  logic          we;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata_q;

  // The clear sweep and a download never overlap, so priority is arbitrary.
  always_comb begin
    we    = clr_we | ld_we;
    waddr = clr_we ? clr_addr  : ld_addr;
    wdata = clr_we ? clr_wdata : ld_wdata;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instmem_prog_v3.sv
// Writable instruction memory: NOP sweep after reset, word-serial download, registered fetch.
// Optional stored-parity checking is enabled by defining INSTMEM_PARITY_EN.
module instmem_prog_v3 #(
  parameter int          DEPTH    = instmem_pkg::DEFAULT_DEPTH,
  parameter int          AW       = $clog2(DEPTH),
  parameter logic [31:0] NOP_WORD = instmem_pkg::NOP_WORD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  input  logic          f_req,
  output logic          f_gnt,
  input  logic [31:0]   f_addr,
  output logic          f_valid,
  output logic [31:0]   f_inst,
  output logic          f_fault,
  output logic          busy,
  output logic [AW:0]   ld_count
`ifdef INSTMEM_PARITY_EN
  ,output logic [7:0]   par_err_cnt
`endif
);
  import instmem_pkg::*;

`ifdef INSTMEM_PARITY_EN
  localparam int MW = 33;
`else
  localparam int MW = 32;
`endif

  function automatic logic [MW-1:0] mk_entry(input logic [31:0] w);
`ifdef INSTMEM_PARITY_EN
    return {even_par(w), w};
`else
    return w;
`endif
  endfunction

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW:0]   ld_count_q, ld_count_d;
  logic          f_valid_q, f_valid_d;
  logic          fault_q, fault_d;
  logic          clr_we, ld_we, par_bad;
  logic [MW-1:0] clr_wdata, ld_wdata, rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      wp_q       <= '0;
      ld_count_q <= '0;
      f_valid_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wp_q       <= wp_d;
      ld_count_q <= ld_count_d;
      f_valid_q  <= f_valid_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (cnt_q == AW'(DEPTH - 1)) state_d = READY;
      READY:   if (ld_start) state_d = LOAD;
      LOAD:    if (ld_valid && (ld_last || wp_q == AW'(DEPTH - 1))) state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  // A download request takes priority over a fetch in the same cycle.
  always_comb begin
    ld_ready = (state_q == LOAD);
    busy     = (state_q != READY);
    f_gnt    = f_req && (state_q == READY) && !ld_start;
    clr_we   = (state_q == CLEAR);
    ld_we    = (state_q == LOAD) && ld_valid;
  end

  always_comb begin
    cnt_d      = cnt_q;
    wp_d       = wp_q;
    ld_count_d = ld_count_q;
    if (clr_we) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (state_q == READY && ld_start) begin
      wp_d       = '0;
      ld_count_d = '0;
    end
    if (ld_we) begin
      wp_d       = wp_q + 1'b1;
      ld_count_d = ld_count_q + 1'b1;
    end
    f_valid_d = f_gnt;
    fault_d   = f_gnt && ((f_addr[1:0] != 2'b00) || (f_addr[31:AW+2] != '0));
    clr_wdata = mk_entry(NOP_WORD);
    ld_wdata  = mk_entry(ld_data);
  end

  instmem_ram_1r1w #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (MW)
  ) u_ram (
    .clk       (clk),
    .clr_we    (clr_we),
    .clr_addr  (cnt_q),
    .clr_wdata (clr_wdata),
    .ld_we     (ld_we),
    .ld_addr   (wp_q),
    .ld_wdata  (ld_wdata),
    .re        (f_gnt),
    .raddr     (f_addr[AW+1:2]),
    .rdata     (rd_data)
  );

`ifdef INSTMEM_PARITY_EN
  logic [7:0] par_err_cnt_q, par_err_cnt_d;

  always_comb begin
    par_bad       = ^rd_data;
    par_err_cnt_d = par_err_cnt_q;
    if (f_valid_q && !fault_q && par_bad && par_err_cnt_q != 8'hFF) begin
      par_err_cnt_d = par_err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err_cnt_q <= '0;
    end else begin
      par_err_cnt_q <= par_err_cnt_d;
    end
  end

  assign par_err_cnt = par_err_cnt_q;
`else
  assign par_bad = 1'b0;
`endif

  // Output word is forced to NOP whenever nothing valid or the fetch faulted.
  always_comb begin
    f_valid  = f_valid_q;
    f_fault  = f_valid_q && (fault_q || par_bad);
    f_inst   = (f_valid_q && !f_fault) ? rd_data[31:0] : NOP_WORD;
    ld_count = ld_count_q;
  end

endmodule

// File: tb/tb_instmem_prog_v3.sv
// Randomised scoreboard bench for instmem_prog_v3 (DEPTH=64).
module tb_instmem_prog_v3;

  localparam int          DEPTH = 64;
  localparam int          AW    = 6;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
  logic [31:0] ld_data = '0;
  logic        f_req = 1'b0;
  logic [31:0] f_addr = '0;
  logic        ld_ready, f_gnt, f_valid, f_fault, busy;
  logic [31:0] f_inst;
  logic [AW:0] ld_count;
`ifdef INSTMEM_PARITY_EN
  logic [7:0]  par_err_cnt;
`endif

  always #5 clk = ~clk;

  instmem_prog_v3 #(.DEPTH(DEPTH)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .f_req    (f_req),
    .f_gnt    (f_gnt),
    .f_addr   (f_addr),
    .f_valid  (f_valid),
    .f_inst   (f_inst),
    .f_fault  (f_fault),
    .busy     (busy),
    .ld_count (ld_count)
`ifdef INSTMEM_PARITY_EN
    ,.par_err_cnt (par_err_cnt)
`endif
  );

  typedef struct packed {
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_mem [DEPTH];
  bit          par_bad [DEPTH];
  int          total = 0;
  int          bad   = 0;
  bit          last_gnt = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference behaviour: byte address -> word or NOP with fault.
  function automatic exp_t model(input logic [31:0] a);
    exp_t e;
    if (a[1:0] != 2'b00 || a >= 32'(DEPTH * 4) || par_bad[a >> 2]) begin
      e.inst  = NOP;
      e.fault = 1'b1;
    end else begin
      e.inst  = ref_mem[a >> 2];
      e.fault = 1'b0;
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever a fetch result is presented.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_gnt = 1'b0;
    end else begin
      check("f_valid_timing", 32'(f_valid), 32'(last_gnt));
      if (f_valid) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow actual=f_valid required=no_result");
        end else begin
          e = sb_q.pop_front();
          $display("fetch result inst=%h fault=%b expect inst=%h fault=%b",
                   f_inst, f_fault, e.inst, e.fault);
          check("f_inst", f_inst, e.inst);
          check("f_fault", 32'(f_fault), 32'(e.fault));
        end
      end
      last_gnt = f_gnt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (3) tick();
    check("sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic reset_and_clear();
    int n;
    rst = 1'b1;
    ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    f_req = 1'b1; f_addr = '0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_f_valid", 32'(f_valid), 32'd0);
    check("rst_f_gnt", 32'(f_gnt), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_ld_count", 32'(ld_count), 32'd0);
    check("rst_f_inst", f_inst, NOP);
    check("rst_f_fault", 32'(f_fault), 32'd0);
    f_req = 1'b0;
    sb_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = NOP;
      par_bad[i] = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      @(posedge clk);
    end
    check("clear_cycles", 32'(n), 32'(DEPTH));
    tick();
  endtask

  task automatic fetch(input logic [31:0] a);
    f_req = 1'b1;
    f_addr = a;
    @(negedge clk);
    check("f_gnt_single", 32'(f_gnt), 32'd1);
    if (f_gnt) sb_q.push_back(model(a));
    tick();
    f_req = 1'b0;
  endtask

  task automatic fetch_burst(input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      f_req = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 5))
        0: a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        1: begin
          a = $urandom;
          if (a[31:8] == 24'd0) a[8] = 1'b1;
        end
        default: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      endcase
      f_addr = a;
      @(negedge clk);
      check("f_gnt_burst", 32'(f_gnt), 32'(f_req));
      if (f_gnt) sb_q.push_back(model(a));
      tick();
    end
    f_req = 1'b0;
    drain();
  endtask

  task automatic load(input int n, input bit use_last, input bit hold_req, input int abort_after);
    int          i, guard;
    logic [31:0] word;
    if (hold_req) begin
      f_req = 1'b1;
      f_addr = '0;
    end
    ld_start = 1'b1;
    @(negedge clk);
    check("gnt_on_ld_start", 32'(f_gnt), 32'd0);
    check("ld_ready_idle", 32'(ld_ready), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    tick();
    ld_start = 1'b0;
    i = 0;
    guard = 0;
    while (i < n && guard < 10000) begin
      ld_valid = ($urandom_range(0, 3) != 0);
      word     = (i == 0) ? 32'h0040_0493 : $urandom;
      ld_data  = word;
      ld_last  = use_last && (i == n - 1);
      @(negedge clk);
      check("ld_ready_load", 32'(ld_ready), 32'd1);
      check("busy_load", 32'(busy), 32'd1);
      if (hold_req) check("gnt_in_load", 32'(f_gnt), 32'd0);
      if (ld_valid) begin
        ref_mem[i] = word;
        par_bad[i] = 1'b0;
        i++;
      end
      tick();
      guard++;
      if (abort_after >= 0 && i == abort_after) break;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    if (guard >= 10000) check("load_timeout", 32'(i), 32'(n));
    if (abort_after >= 0) begin
      check("ld_count_partial", 32'(ld_count), 32'(abort_after));
      return;
    end
    check("ld_count", 32'(ld_count), 32'(n));
    check("busy_after_load", 32'(busy), 32'd0);
    if (hold_req) begin
      @(negedge clk);
      check("gnt_resume", 32'(f_gnt), 32'd1);
      if (f_gnt) sb_q.push_back(model(f_addr));
      tick();
      f_req = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = NOP;
      par_bad[i] = 1'b0;
    end
    #1;
    reset_and_clear();

    fetch(32'h0000_0000);
    fetch(32'h0000_007C);
    drain();

    load(55, 1'b1, 1'b0, -1);
    fetch(32'h0000_0000);
    check("model_word0", ref_mem[0], 32'h0040_0493);
    fetch(32'h0000_000C);
    fetch(32'h0000_00D8);
    fetch(32'h0000_00DC);
    drain();

    fetch(32'h0000_0002);
    fetch(32'h0000_0100);
    drain();

    fetch_burst(40);

    load(20, 1'b1, 1'b1, -1);
    fetch_burst(40);

    load(DEPTH, 1'b0, 1'b0, -1);
    fetch(32'h0000_00FC);
    fetch_burst(30);

    load(30, 1'b1, 1'b0, 10);
    reset_and_clear();
    fetch(32'h0000_0000);
    drain();

`ifdef INSTMEM_PARITY_EN
    load(8, 1'b1, 1'b0, -1);
    u_dut.u_ram.mem[3][0] = ~u_dut.u_ram.mem[3][0];
    par_bad[3] = 1'b1;
    fetch(32'h0000_000C);
    fetch(32'h0000_0010);
    drain();
    check("par_err_cnt", 32'(par_err_cnt), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instmem_prog_v3.md
Name: instmem_prog_v3

Overview:
- Parametrised, writable successor to the fixed AES instruction ROM of the RV32IMV_V2 core.
- Holds DEPTH 32-bit instruction words in a RAM array.
- After reset, sweeps every entry to NOP. A host then downloads a program through a word-serial load port. Once loaded, it serves core fetches with a one-cycle registered read and a valid/ready handshake.
- Sits between the core fetch stage and the host/boot loader; lets AES kernel variants (AES-128/192/256) be swapped without re-synthesis.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, 16..4096.
- AW, $clog2(DEPTH), word-index width.
- NOP_WORD, 32'h00000013, fill value (addi x0,x0,0) used at clear and for faulted fetches.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld_start  in  1  pulse: begin program download (accepted only in READY).
- ld_valid  in  1  load word valid.
- ld_ready  out  1  block can accept a load word.
- ld_data  in  32  instruction word; written to consecutive addresses starting at 0.
- ld_last  in  1  marks the final load word.
- f_req  in  1  fetch request valid.
- f_gnt  out  1  fetch accepted this cycle.
- f_addr  in  32  byte address from PC.
- f_valid  out  1  fetch data valid (one cycle after grant).
- f_inst  out  32  fetched instruction.
- f_fault  out  1  with f_valid: misaligned or out-of-range fetch.
- busy  out  1  high in CLEAR or LOAD.
- ld_count  out  AW+1  words loaded in the last/current download.

Behaviour:
- Reset values: state=CLEAR, clear counter=0, ld_ready=0, f_gnt=0, f_valid=0, f_inst=NOP_WORD, f_fault=0, busy=1, ld_count=0. Memory contents are not reset asynchronously; the CLEAR sweep initialises them.
- FSM CLEAR:
  - Writes NOP_WORD to index cnt each cycle; cnt increments.
  - When cnt==DEPTH-1 is written, go to READY. CLEAR lasts exactly DEPTH cycles.
- FSM READY:
  - busy=0; fetches are served.
  - ld_start=1 goes to LOAD, resets the write pointer and ld_count to 0, and grants no fetch that cycle.
- FSM LOAD:
  - ld_ready=1.
  - On ld_valid&&ld_ready, writes ld_data to mem[wp]; wp++ and ld_count++.
  - ld_last, or writing index DEPTH-1, returns to READY. Words past DEPTH are impossible by construction.
  - Unwritten entries keep their prior contents.
  - f_gnt=0 throughout LOAD and CLEAR.
- Fetch handshake:
  - f_gnt = f_req && state==READY && !ld_start. This is combinational from registered state and ld_start.
  - On grant, the word index f_addr[AW+1:2] is registered; f_valid=1 the next cycle with f_inst=mem[index].
  - Back-to-back grants give one word per cycle. f_valid drops the cycle after a cycle with no grant.
- Fault conditions (both give f_inst=NOP_WORD and f_fault=1, still with f_valid=1):
  - f_addr[1:0]!=0 (misaligned).
  - f_addr[31:AW+2]!=0 (out of range).
- Same-cycle ld_start and f_req in READY: load wins, fetch is not granted.
- Read-during-write: not possible, since writes occur only when no fetch is granted.
- rst mid-LOAD or mid-CLEAR: immediately returns to CLEAR. Pending f_valid is cleared and the program is lost.

Optional Feature:
- Macro INSTMEM_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit, computed on write (CLEAR and LOAD).
  - On fetch, a recomputed parity mismatch sets f_fault=1 and forces f_inst=NOP_WORD.
  - Extra output par_err_cnt (8 bits, saturating at 255, reset 0) counts mismatches.
- Not defined: memory is 32 bits wide, no parity check, and par_err_cnt is absent.

Decomposition:
- Package instmem_pkg holds:
  - State enum {CLEAR, READY, LOAD}.
  - NOP_WORD.
  - The default DEPTH.
  - A parity function.
- One sub-module, instmem_ram_1r1w: a synchronous-write, registered-read array with a mux selecting the single write port between the clear and load paths.
- FSM, handshake and fault logic live in the top.

Test Plan:
1. Reset, wait 64 cycles with DEPTH=64 -> busy falls on cycle 64; fetch of 0x00, 0x7C returns 0x00000013, f_fault=0, f_valid exactly 1 cycle after f_gnt.
2. Load 55 words of the AES-128 key-schedule/enc/dec program, ld_last on word 55 -> ld_count=55; fetch 0x00 gives 0x00400493, fetch 0x0C gives 0x0200_0107-style stored word (compare to loaded image); fetch 0xDC returns NOP.
3. Fetch 0x02 and fetch 0x100 (DEPTH=64) -> f_inst=0x00000013, f_fault=1 on both.
4. f_req held high with ld_start pulsed same cycle -> f_gnt=0 that cycle and throughout LOAD; grants resume the cycle after return to READY.
5. Assert rst after 10 load words -> busy=1, 64-cycle CLEAR, then fetch 0x00 returns NOP (program erased).
6. With INSTMEM_PARITY_EN defined, force-flip one stored bit at index 3, then fetch 0x0C -> f_fault=1, f_inst=NOP, par_err_cnt=1.
